mult_issue_sequencer: RTL

MULT_ISSUE_SEQUENCER -- requirements
Module: mult_issue_sequencer

---
 rtl/mult_issue_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mult_issue_sequencer.sv
// mult_issue_sequencer
// Buffers 4-bit operand pairs in a small circular FIFO and issues them one
// at a time to an external mult_4x4 using a start/finish level handshake.
// Each product is held on a valid/ready output until it is taken. A job
// whose finish never arrives is dropped after TIMEOUT cycles and raises a
// sticky error flag. The multiplier is only restarted after its finish
// line has been seen low again.
module mult_issue_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  output logic                     mul_start,
  output logic [3:0]               mul_a,
  output logic [3:0]               mul_b,
  input  logic [7:0]               mul_o,
  input  logic                     mul_finish,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_prod,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;

  // Operand storage: each entry is {a, b}.
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      head;

  logic [TW-1:0]   timer;

  logic            push;
  logic            pop;
  logic            capture;
  logic            timeout_hit;
  logic            release_out;

  // Readiness comes only from the registered occupancy, so a pop on the same
  // edge never lets a push into a full FIFO. Held low throughout reset.
  assign in_ready = reset && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // State register for the issue FSM.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle event decode for the issue FSM.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    release_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A finish on the same edge as the timeout takes precedence.
        if (mul_finish) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = DRAIN;
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // Wait for the multiplier to drop finish before issuing again.
        if (!mul_finish) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; entries are only
    // ever read behind the reset-cleared pointers, so stale data is unreachable.
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b};
    end
  end

  // Multiplier interface, wait timer, product register and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      timer     <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      err       <= 1'b0;
    end else begin
      if (pop) begin
        mul_a     <= head[7:4];
        mul_b     <= head[3:0];
        mul_start <= 1'b1;
        timer     <= '0;
      end
      if (state_q == WAIT && !capture && !timeout_hit) begin
        timer <= timer + TW'(1);
      end
      if (capture) begin
        out_prod  <= mul_o;
        out_valid <= 1'b1;
        mul_start <= 1'b0;
      end
      if (timeout_hit) begin
        err       <= 1'b1;
        mul_start <= 1'b0;
      end
      if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
